// File: rtl/afg_stretch_pkg.sv
// Shared types and defaults for the increment-path pulse stretcher.
//   DefaultCh    - default number of channels
//   DefaultCntW  - default width of Len and of each channel counter
//   DefaultAcW   - default width of the active-channel count
//   len_t        - stretch length type at the default counter width
//   len_eff()    - maps a programmed length of 0 to 1 cycle
package afg_stretch_pkg;

  localparam int unsigned DefaultCh   = 4;
  localparam int unsigned DefaultCntW = 4;
  localparam int unsigned DefaultAcW  = 3;

  typedef logic [DefaultCntW-1:0] len_t;

  // A zero length would never raise Dout, so treat it as the shortest pulse.
  function automatic len_t len_eff(input len_t len);
    return (len == '0) ? len_t'(1) : len;
  endfunction

endpackage

// File: rtl/stretch_chan.sv
// One pulse-stretcher channel: down-counter, trigger acceptance, registered Dout.
// Optional macro STRETCH_EDGE_EN: trigger on the rising edge of din_i (adds a
// history flop); otherwise din_i is a level trigger.
// Ports:
//   clk_i      - clock
//   rst_ni     - asynchronous active-low reset
//   din_i      - trigger input
//   len_i      - stretch length, sampled only when a trigger is accepted
//   retrig_i   - 1: reload on every trigger; 0: accept only when idle
//   clear_i    - synchronous clear, overrides triggers
//   dout_o     - registered stretched pulse
//   dout_d_o   - next-state of dout_o, for the parent's popcount register
module stretch_chan
  import afg_stretch_pkg::*;
#(
  parameter int unsigned CntW = DefaultCntW
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            din_i,
  input  logic [CntW-1:0] len_i,
  input  logic            retrig_i,
  input  logic            clear_i,
  output logic            dout_o,
  output logic            dout_d_o
);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] len_eff_w;
  logic            trig;
  logic            accept;
  logic            dout_q, dout_d;

  if (CntW == DefaultCntW) begin : g_len_pkg
    assign len_eff_w = len_eff(len_i);
  end else begin : g_len_local
    assign len_eff_w = (len_i == '0) ? CntW'(1) : len_i;
  end

`ifdef STRETCH_EDGE_EN
  logic din_q;

  // History keeps updating through Clear so a level held across Clear
  // does not retrigger afterwards.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din_i;
    end
  end

  assign trig = din_i & ~din_q;
`else
  assign trig = din_i;
`endif

  always_comb begin
    cnt_d  = cnt_q;
    accept = trig & (retrig_i | (cnt_q == '0));
    if (clear_i) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = len_eff_w;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
    dout_d = (cnt_d != '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout_o   = dout_q;
  assign dout_d_o = dout_d;

endmodule

// File: rtl/inc_pulse_stretch.sv
// Multi-channel pulse stretcher for the function-generator increment path.
// Each channel widens a Din trigger into a Len-cycle Dout pulse; Active_Cnt
// counts channels whose Dout is high.
// Optional macro STRETCH_EDGE_EN: channels trigger on Din rising edges.
// Ports:
//   Clock      - clock, rising edge
//   Reset      - asynchronous active-low reset
//   Din        - per-channel triggers
//   Len        - stretch length (0 behaves as 1), shared by all channels
//   Retrig     - 1 retriggerable, 0 non-retriggerable
//   Clear      - synchronous clear of all channels
//   Dout       - registered stretched pulses
//   Active_Cnt - registered popcount of Dout
module inc_pulse_stretch
  import afg_stretch_pkg::*;
#(
  parameter int unsigned CH    = DefaultCh,
  parameter int unsigned CNT_W = DefaultCntW,
  parameter int unsigned AC_W  = DefaultAcW  // needs 2**AC_W > CH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [CH-1:0]    Din,
  input  logic [CNT_W-1:0] Len,
  input  logic             Retrig,
  input  logic             Clear,
  output logic [CH-1:0]    Dout,
  output logic [AC_W-1:0]  Active_Cnt
);

  logic [CH-1:0]   dout_next;
  logic [AC_W-1:0] active_cnt_q, active_cnt_d;

  for (genvar i = 0; i < CH; i++) begin : g_chan
    stretch_chan #(
      .CntW (CNT_W)
    ) u_chan (
      .clk_i    (Clock),
      .rst_ni   (Reset),
      .din_i    (Din[i]),
      .len_i    (Len),
      .retrig_i (Retrig),
      .clear_i  (Clear),
      .dout_o   (Dout[i]),
      .dout_d_o (dout_next[i])
    );
  end

  // Count from next-state so the count moves on the same edge as Dout.
  always_comb begin
    active_cnt_d = '0;
    for (int i = 0; i < int'(CH); i++) begin
      active_cnt_d = active_cnt_d + AC_W'(dout_next[i]);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      active_cnt_q <= '0;
    end else begin
      active_cnt_q <= active_cnt_d;
    end
  end

  assign Active_Cnt = active_cnt_q;

endmodule

// File: tb/tb_inc_pulse_stretch.sv
module tb_inc_pulse_stretch;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [3:0] Din = '0;
  logic [3:0] Len = '0;
  logic       Retrig = 1'b0;
  logic       Clear = 1'b0;
  logic [3:0] Dout;
  logic [2:0] Active_Cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference: cycles of high output still owed per channel.
  int         rem[4];
  bit         prev[4];
  logic [3:0] q_dout[$];
  logic [2:0] q_ac[$];

  inc_pulse_stretch dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Din        (Din),
    .Len        (Len),
    .Retrig     (Retrig),
    .Clear      (Clear),
    .Dout       (Dout),
    .Active_Cnt (Active_Cnt)
  );

  always #5 Clock = ~Clock;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      rem[i]  = 0;
      prev[i] = 1'b0;
    end
  endtask

  // Advance the reference by one edge using the current inputs.
  task automatic model_step();
    logic [3:0] ed;
    int         n;
    int         le;
    bit         t;
    ed = '0;
    n  = 0;
    le = (Len == 0) ? 1 : int'(Len);
    for (int i = 0; i < 4; i++) begin
`ifdef STRETCH_EDGE_EN
      t = Din[i] && !prev[i];
`else
      t = Din[i];
`endif
      if (Clear) rem[i] = 0;
      else if (t && (Retrig || rem[i] == 0)) rem[i] = le;
      else if (rem[i] > 0) rem[i] = rem[i] - 1;
      prev[i] = Din[i];
      if (rem[i] != 0) begin
        ed[i] = 1'b1;
        n++;
      end
    end
    q_dout.push_back(ed);
    q_ac.push_back(3'(n));
  endtask

  task automatic drive(input logic [3:0] d, input logic [3:0] l, input logic r,
                       input logic c);
    @(negedge Clock);
    Din    = d;
    Len    = l;
    Retrig = r;
    Clear  = c;
    model_step();
  endtask

  task automatic idle(input int n, input logic [3:0] l, input logic r);
    for (int k = 0; k < n; k++) drive(4'b0000, l, r, 1'b0);
  endtask

  // Assert reset between edges and check outputs drop without a clock.
  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b0;
    Din   = '0;
    Clear = 1'b0;
    #1;
    checks++;
    if (Dout !== 4'b0000 || Active_Cnt !== 3'd0) begin
      failures++;
      $display("FAIL async_reset t=%0t dout=%b active=%0d required dout=0000 active=0",
               $time, Dout, Active_Cnt);
    end
    model_reset();
    @(negedge Clock);
    Reset = 1'b1;
    model_step();
  endtask

  // Monitor: one expected entry per edge, compared just after the edge.
  initial begin
    logic [3:0] ed;
    logic [2:0] ea;
    forever begin
      @(posedge Clock);
      cyc++;
      #1;
      if (q_dout.size() > 0) begin
        ed = q_dout.pop_front();
        ea = q_ac.pop_front();
        checks++;
        if (Dout !== ed || Active_Cnt !== ea) begin
          failures++;
          $display("FAIL scoreboard cyc=%0d dout=%b active=%0d required dout=%b active=%0d",
                   cyc, Dout, Active_Cnt, ed, ea);
        end
      end
    end
  end

  initial begin
    model_reset();
    do_reset();

    // Baseline: Len=2, retriggerable, single-cycle pulse on channel 1.
    drive(4'b0010, 4'd2, 1'b1, 1'b0);
    idle(4, 4'd2, 1'b1);

    // Retrigger: Len=4, channel 2 pulsed at cycles 0 and 2.
    drive(4'b0100, 4'd4, 1'b1, 1'b0);
    drive(4'b0000, 4'd4, 1'b1, 1'b0);
    drive(4'b0100, 4'd4, 1'b1, 1'b0);
    idle(6, 4'd4, 1'b1);

    // Non-retrigger: channel 3 held high for 10 cycles, Len=3.
    for (int k = 0; k < 10; k++) drive(4'b1000, 4'd3, 1'b0, 1'b0);
    idle(5, 4'd3, 1'b0);

    // Clear with all triggers coincident, mid-pulse on some channels.
    drive(4'b0011, 4'd6, 1'b1, 1'b0);
    drive(4'b0000, 4'd6, 1'b1, 1'b0);
    drive(4'b1111, 4'd6, 1'b1, 1'b1);
    idle(3, 4'd6, 1'b1);

    // Len=0 behaves as 1; Len=15 with no wrap.
    drive(4'b0001, 4'd0, 1'b1, 1'b0);
    idle(3, 4'd0, 1'b1);
    drive(4'b0010, 4'd15, 1'b1, 1'b0);
    idle(18, 4'd0, 1'b1);

    // Len changes after acceptance do not affect the pulse in flight.
    drive(4'b0100, 4'd5, 1'b0, 1'b0);
    idle(7, 4'd1, 1'b0);

    // Active_Cnt: staggered triggers, Len=8.
    drive(4'b0001, 4'd8, 1'b1, 1'b0);
    drive(4'b0010, 4'd8, 1'b1, 1'b0);
    drive(4'b0100, 4'd8, 1'b1, 1'b0);
    drive(4'b1000, 4'd8, 1'b1, 1'b0);
    idle(10, 4'd8, 1'b1);

    // Reset mid-pulse (cnt=5), then a clean Len=3 pulse.
    drive(4'b0001, 4'd5, 1'b1, 1'b0);
    do_reset();
    drive(4'b0001, 4'd3, 1'b1, 1'b0);
    idle(5, 4'd3, 1'b1);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      drive(4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 24) == 0));
    end
    idle(17, 4'd1, 1'b1);

    @(posedge Clock);
    #2;
    checks++;
    if (q_dout.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required 0", q_dout.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
